// File: rtl/tx_parity_engine.sv
// Bit-serial UART TX parity generator: even/odd/mark/space/disabled over a runtime frame length.
// Optional TX_PAR_FORCE_ERR_EN adds a force_err input that inverts the produced parity bit.
module tx_parity_engine #(
  parameter int unsigned data_width = 8,
  parameter int unsigned LEN_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [data_width-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  Busy,
  input  logic                  par_en,
  input  logic [1:0]            par_typ,
  input  logic [LEN_W-1:0]      data_len,
`ifdef TX_PAR_FORCE_ERR_EN
  input  logic                  force_err,
`endif
  output logic                  par_bit,
  output logic                  par_valid,
  output logic                  par_busy
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                state, state_n;
  logic [data_width-1:0] data_reg;
  logic                  acc;
  logic [LEN_W-1:0]      cnt;
  logic [LEN_W-1:0]      len_q;
  logic [LEN_W-1:0]      len_eff;
  logic                  en_q;
  logic [1:0]            typ_q;
  logic                  load;
  logic                  capture;
  logic                  last;
  logic                  par_n;
  logic                  par_out;

  assign par_busy = (state == CALC);
  assign capture  = data_valid && !Busy && !par_busy;
  assign last     = (cnt == len_q - LEN_W'(1));

  always_comb begin
    len_eff = data_len;
    if (data_len == '0 || data_len > LEN_W'(data_width))
      len_eff = LEN_W'(data_width);
  end

  always_comb begin
    par_n = 1'b0;
    if (en_q) begin
      case (typ_q)
        2'b00:   par_n = acc;
        2'b01:   par_n = ~acc;
        2'b10:   par_n = 1'b1;
        default: par_n = 1'b0;
      endcase
    end
  end

`ifdef TX_PAR_FORCE_ERR_EN
  logic fe_q;

  assign par_out = par_n ^ fe_q;

  always_ff @(posedge clk) begin
    if (rst)
      fe_q <= 1'b0;
    else if (capture)
      fe_q <= force_err;
  end
`else
  assign par_out = par_n;
`endif

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (capture) state_n = CALC;
      CALC:    if (last)    state_n = DONE;
      DONE:    if (capture) state_n = CALC;
      default: state_n = IDLE;
    endcase
  end

  // data_reg shifts right so bit 0 is always the next bit to fold in;
  // load delays the result by one cycle after the final accumulate.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      data_reg  <= '0;
      acc       <= 1'b0;
      cnt       <= '0;
      len_q     <= '0;
      en_q      <= 1'b0;
      typ_q     <= '0;
      load      <= 1'b0;
      par_bit   <= 1'b0;
      par_valid <= 1'b0;
    end else begin
      state <= state_n;
      load  <= 1'b0;
      if (capture) begin
        data_reg  <= p_data;
        acc       <= 1'b0;
        cnt       <= '0;
        len_q     <= len_eff;
        en_q      <= par_en;
        typ_q     <= par_typ;
        par_valid <= 1'b0;
      end else if (state == CALC) begin
        acc      <= acc ^ data_reg[0];
        data_reg <= data_reg >> 1;
        cnt      <= cnt + LEN_W'(1);
        load     <= last;
      end else if (load) begin
        par_bit   <= par_out;
        par_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tx_parity_engine.sv
// Self-checking bench for tx_parity_engine: frame vector table with a latency/parity scoreboard
// plus hand-written reset, refusal and back-to-back sequences.
module tb_tx_parity_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] p_data;
  logic       data_valid;
  logic       Busy;
  logic       par_en;
  logic [1:0] par_typ;
  logic [3:0] data_len;
  logic       force_err;
  logic       par_bit;
  logic       par_valid;
  logic       par_busy;

  int nerr = 0;
  int nchk = 0;

  typedef struct {
    logic [7:0] d;
    logic       en;
    logic [1:0] typ;
    logic [3:0] len;
    logic       fe;
    logic       exp_bit;
    int         lat;
  } vec_t;

  typedef struct {
    logic exp_bit;
    int   lat;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  tx_parity_engine #(.data_width(8), .LEN_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .p_data     (p_data),
    .data_valid (data_valid),
    .Busy       (Busy),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .data_len   (data_len),
`ifdef TX_PAR_FORCE_ERR_EN
    .force_err  (force_err),
`endif
    .par_bit    (par_bit),
    .par_valid  (par_valid),
    .par_busy   (par_busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Captures one frame, scrambles the inputs during CALC, and scores parity and timing.
  task automatic run_frame(input vec_t v, input bit intrude, input string name);
    int   n;
    int   busy_end;
    exp_t e;
    p_data     = v.d;
    par_en     = v.en;
    par_typ    = v.typ;
    data_len   = v.len;
    force_err  = v.fe;
    data_valid = 1'b1;
    sb.push_back('{v.exp_bit, v.lat});
    step();
    data_valid = 1'b0;
    p_data     = ~v.d;
    par_typ    = v.typ ^ 2'b01;
    par_en     = ~v.en;
    data_len   = 4'd3;
    force_err  = ~v.fe;
    check({name, " busy_at_capture"}, par_busy, 1);
    check({name, " valid_cleared"}, par_valid, 0);
    n = 0;
    busy_end = -1;
    while (!par_valid && n < 40) begin
      if (intrude && n == 1) begin
        data_valid = 1'b1;
        p_data     = 8'h07;
      end
      if (intrude && n == 3) data_valid = 1'b0;
      step();
      n++;
      if (!par_busy && busy_end < 0) busy_end = n;
    end
    data_valid = 1'b0;
    e = sb.pop_front();
    check({name, " latency"}, n, e.lat);
    check({name, " busy_len"}, busy_end, e.lat - 1);
    check({name, " par_bit"}, par_bit, e.exp_bit);
    step();
    check({name, " held"}, {par_valid, par_bit}, {1'b1, e.exp_bit});
  endtask

  initial begin
    bit seen;
    rst = 1'b1; p_data = '0; data_valid = 1'b0; Busy = 1'b0;
    par_en = 1'b0; par_typ = '0; data_len = '0; force_err = 1'b0;

    //            d      en    typ    len   fe    bit   lat
    vecs.push_back('{8'hA5, 1'b1, 2'b00, 4'd8,  1'b0, 1'b0, 9});
    vecs.push_back('{8'hA5, 1'b1, 2'b01, 4'd8,  1'b0, 1'b1, 9});
    vecs.push_back('{8'h07, 1'b1, 2'b00, 4'd8,  1'b0, 1'b1, 9});
    vecs.push_back('{8'hFF, 1'b1, 2'b00, 4'd5,  1'b0, 1'b1, 6});
    vecs.push_back('{8'hFF, 1'b1, 2'b00, 4'd0,  1'b0, 1'b0, 9});
    vecs.push_back('{8'hFF, 1'b1, 2'b00, 4'd12, 1'b0, 1'b0, 9});
    vecs.push_back('{8'h00, 1'b1, 2'b10, 4'd8,  1'b0, 1'b1, 9});
    vecs.push_back('{8'hFF, 1'b1, 2'b11, 4'd8,  1'b0, 1'b0, 9});
    vecs.push_back('{8'h00, 1'b0, 2'b01, 4'd8,  1'b0, 1'b0, 9});
    vecs.push_back('{8'hFF, 1'b0, 2'b10, 4'd8,  1'b0, 1'b0, 9});
    vecs.push_back('{8'h01, 1'b1, 2'b00, 4'd1,  1'b0, 1'b1, 2});
    vecs.push_back('{8'h02, 1'b1, 2'b00, 4'd1,  1'b0, 1'b0, 2});
    vecs.push_back('{8'h0F, 1'b1, 2'b01, 4'd4,  1'b0, 1'b1, 5});
    vecs.push_back('{8'h80, 1'b1, 2'b01, 4'd7,  1'b0, 1'b1, 8});
`ifdef TX_PAR_FORCE_ERR_EN
    vecs.push_back('{8'hA5, 1'b1, 2'b00, 4'd8,  1'b1, 1'b1, 9});
    vecs.push_back('{8'hFF, 1'b1, 2'b11, 4'd8,  1'b1, 1'b1, 9});
    vecs.push_back('{8'h00, 1'b0, 2'b00, 4'd8,  1'b1, 1'b1, 9});
    vecs.push_back('{8'h07, 1'b1, 2'b00, 4'd8,  1'b0, 1'b1, 9});
`endif

    step(); step();
    check("reset_outputs", {par_bit, par_valid, par_busy}, 3'b000);
    rst = 1'b0;
    step();

    // Reset three cycles into CALC; the aborted word must never report.
    p_data = 8'hA5; par_en = 1'b1; par_typ = 2'b00; data_len = 4'd8; data_valid = 1'b1;
    step();
    data_valid = 1'b0;
    step(); step(); step();
    check("midcalc_busy_before_rst", par_busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midcalc_rst_outputs", {par_busy, par_valid}, 2'b00);
    seen = 1'b0;
    for (int unsigned i = 0; i < 15; i++) begin
      step();
      if (par_valid || par_busy) seen = 1'b1;
    end
    check("midcalc_no_valid", seen, 0);

    // rst wins over a simultaneous data_valid.
    p_data = 8'h01; data_valid = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0; data_valid = 1'b0;
    check("rst_priority", par_busy, 0);

    for (int unsigned i = 0; i < vecs.size(); i++)
      run_frame(vecs[i], 1'b0, $sformatf("vec%0d", i));

    // Captures refused while the serializer is busy; previous result stays.
    Busy = 1'b1; p_data = 8'h01; par_typ = 2'b00; data_len = 4'd8; data_valid = 1'b1;
    step(); step(); step();
    check("busy_refused", {par_busy, par_valid, par_bit}, {1'b0, 1'b1, vecs[vecs.size()-1].exp_bit});
    data_valid = 1'b0; Busy = 1'b0;
    step();

    // data_valid during CALC is ignored; result reflects the first word.
    run_frame('{8'hA5, 1'b1, 2'b00, 4'd8, 1'b0, 1'b0, 9}, 1'b1, "intrude");

    // Back-to-back: second capture lands in the DONE cycle of the first.
    run_frame('{8'h01, 1'b1, 2'b00, 4'd8, 1'b0, 1'b1, 9}, 1'b0, "b2b_first");
    run_frame('{8'h03, 1'b1, 2'b00, 4'd8, 1'b0, 1'b0, 9}, 1'b0, "b2b_second");

    check("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/tx_parity_engine.md
# tx_parity_engine

Parametrised parity generator for the UART transmit path, successor to the fixed 8-bit even/odd parity calculator. It captures a data word when the transmitter is idle and computes its parity bit-serially, one data bit per cycle, over a runtime-selectable frame length. It supports five parity modes and signals completion with a `par_valid` strobe. It sits between the TX data interface and the frame serializer/mux, which samples `par_bit` during the parity slot.

## Interface
- `data_width`, default 8 — maximum data bits per frame; legal range 5..15.
- `LEN_W`, default 4 — width of `data_len`; must satisfy 2^LEN_W > data_width.
- `clk`  in  1  — single clock; all logic on its rising edge.
- `rst`  in  1  — reset; synchronous, active-high.
- `p_data`  in  data_width  — parallel TX data; bit 0 is sent first.
- `data_valid`  in  1  — `p_data` is valid this cycle.
- `Busy`  in  1  — the serializer is transmitting a frame.
- `par_en`  in  1  — parity enabled for the captured frame.
- `par_typ`  in  2  — parity mode: 00 even, 01 odd, 10 mark, 11 space.
- `data_len`  in  LEN_W  — data bits in the frame; 0 or >`data_width` means `data_width`.
- `force_err`  in  1  — invert the parity bit (present only with `TX_PAR_FORCE_ERR_EN`).
- `par_bit`  out  1  — computed parity bit.
- `par_valid`  out  1  — `par_bit` is valid for the last captured word.
- `par_busy`  out  1  — computation is in progress; new captures are refused.

## Operation
- **FSM states:** IDLE, CALC, DONE.
- **IDLE / DONE → CALC:** the transition occurs on `data_valid && !Busy && !par_busy`.
  - Capture `p_data` into `data_reg`.
  - Latch `par_en`, `par_typ` and the effective length `len` (after clamping) into configuration registers.
  - Clear `acc` and `cnt`, and clear `par_valid`.
- **CALC:** each cycle, `acc <= acc ^ data_reg[cnt]` and `cnt <= cnt+1`. When `cnt == len-1`, go to DONE. Bits at index ≥ `len` never contribute.
- **Entering DONE:** `par_bit` is loaded from the latched configuration, then `par_valid <= 1`.
  - `par_en=0`: 0.
  - Even: final `acc` (XOR of the `len` bits).
  - Odd: `~acc`.
  - Mark: 1.
  - Space: 0.
  - Mark, space and disabled frames still run CALC, so latency is uniform.
- **DONE:** hold `par_bit` and `par_valid` until the next capture or reset.
- **Input changes:** changes on `p_data`, `par_en`, `par_typ` or `data_len` after capture do not affect the running or finished result.
- **Refused captures:** `data_valid` while `Busy=1` or `par_busy=1` is ignored. Nothing is queued and no error is flagged.
- **`par_busy`:** equals 1 exactly while the state is CALC.

## Timing
- **Reset values (after any cycle with `rst=1`, including mid-CALC):**
  - state = IDLE; `par_bit`=0, `par_valid`=0, `par_busy`=0.
  - `data_reg`=0, `acc`=0, `cnt`=0.
  - The aborted computation produces no `par_valid`.
- **Capture edge E:** `par_busy` is 1 and `par_valid` is 0 from E to E+len.
- **Latency:** `par_bit`/`par_valid` update at edge E+len+1, so `par_valid` goes high `len`+1 cycles after the capture edge. Example: 8 bits → 9 cycles; 5 bits → 6 cycles.
- **Back-to-back:** a capture in the same cycle DONE is present is accepted. `par_valid` drops at that edge.
- **Simultaneous events:** `rst` has priority over `data_valid`.
- **Length boundaries:** `data_len=1` gives a CALC of one cycle. `data_len=0` and `data_len>data_width` both behave exactly as `data_len=data_width`.

## Configuration
- **Macro:** `TX_PAR_FORCE_ERR_EN`.
- **Defined:**
  - A `force_err` port exists and is latched with the configuration at capture.
  - When the latched value is 1, the `par_bit` loaded on entering DONE is inverted, for all modes including disabled and mark/space.
  - Intended for receiver parity-error testing.
- **Undefined:** the port is absent, no latch is built, and `par_bit` is never inverted.

## Test plan
- **Reset mid-CALC:** capture 8'hA5, assert `rst` 3 cycles later for 1 cycle → `par_busy`=0 and `par_valid`=0 next cycle; no `par_valid` ever rises for that word.
- **8-bit even/odd:** `data_len`=8, `p_data`=8'hA5 (four ones), even → `par_bit`=0 and `par_valid`=1 exactly 9 cycles after capture. Same data, odd → 1. `p_data`=8'h07, even → 1.
- **Short frame and clamping:** `data_len`=5, `p_data`=8'hFF, even → 1 (bits 7:5 ignored), `par_valid` after 6 cycles. `data_len`=0 with 8'hFF → 0 after 9 cycles.
- **Mark/space/disabled and capture rules:**
  - Mark on 8'h00 → 1; space on 8'hFF → 0; `par_en`=0 with odd on 8'h00 → 0.
  - `data_valid` with `Busy`=1 → no capture.
  - `data_valid` while `par_busy`=1 → ignored; the result matches the first word.
- **Back-to-back and input isolation:**
  - Capture 8'h01 even, change `p_data`/`par_typ` during CALC → result still 1.
  - Capture 8'h03 in the DONE cycle → `par_valid` drops, then returns with `par_bit`=0.
- **With `TX_PAR_FORCE_ERR_EN`:** `force_err`=1, even, 8'hA5 → `par_bit`=1. Space mode → 1. `force_err` toggled after capture → no effect.
